// File: rtl/hub75_pkg.sv
// Shared HUB75 definitions: RGB bit positions, half-select values, receiver FSM states.
package hub75_pkg;

  localparam int unsigned RGB_R = 2;
  localparam int unsigned RGB_G = 1;
  localparam int unsigned RGB_B = 0;

  localparam logic HUB_HALF_UP = 1'b0;
  localparam logic HUB_HALF_LO = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EMIT_UP = 2'd1,
    ST_EMIT_LO = 2'd2
  } hub_state_e;

endpackage

// File: rtl/hub75_sync_edge.sv
// Multi-stage synchroniser followed by a registered rising-edge detector.
//   i_clk, i_rst_n : local clock, async active-low reset
//   i_d            : asynchronous input
//   o_rise         : one-cycle pulse, SYNC_STAGES+1 cycles after i_d rises
module hub75_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/hub75_rx.sv
// HUB75 panel-input stage: captures shifted row pairs and streams pixels out.
//   hub_*      : asynchronous panel pins (shift clock, latch, OE, row address, RGB pairs)
//   clr_err    : clears len_err / overrun
//   pix_*      : valid/ready pixel stream, row = {half, addr}, upper half first, col 0 first
//   row_done   : pulse in the cycle the last lower-half pixel is accepted
//   oe_active  : synchronised ~hub_oe
//   len_err    : sticky, latch seen with shift count != WIDTH
//   overrun    : sticky, latch seen while a readout was in progress
module hub75_rx
  import hub75_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned ROW_BITS    = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     hub_clk,
  input  logic                     hub_lat,
  input  logic                     hub_oe,
  input  logic [ROW_BITS-1:0]      hub_addr,
  input  logic [2:0]               hub_rgb1,
  input  logic [2:0]               hub_rgb2,
  input  logic                     clr_err,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic [ROW_BITS:0]        pix_row,
  output logic [$clog2(WIDTH)-1:0] pix_col,
  output logic [2:0]               pix_rgb,
  output logic                     row_done,
  output logic                     oe_active,
  output logic                     len_err,
  output logic                     overrun
);

  localparam int unsigned COL_W = $clog2(WIDTH);
  localparam int unsigned CNT_W = $clog2(WIDTH + 2);
  localparam int unsigned DW    = 1 + ROW_BITS + 6;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);

  // Data bus: SYNC_STAGES synchroniser plus one stage matching the edge register.
  logic [DW-1:0] r_dsync [SYNC_STAGES];
  logic [DW-1:0] r_dal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dsync <= '{default: '0};
      r_dal   <= '0;
    end else begin
      r_dsync[0] <= {hub_oe, hub_addr, hub_rgb1, hub_rgb2};
      for (int i = 1; i < int'(SYNC_STAGES); i++) r_dsync[i] <= r_dsync[i-1];
      r_dal <= r_dsync[SYNC_STAGES-1];
    end
  end

  logic                w_oe;
  logic [ROW_BITS-1:0] w_addr;
  logic [2:0]          w_rgb1, w_rgb2;
  assign w_oe   = r_dal[DW-1];
  assign w_addr = r_dal[6 +: ROW_BITS];
  assign w_rgb1 = r_dal[5:3];
  assign w_rgb2 = r_dal[2:0];

  logic w_clk_rise, w_lat_rise;

  hub75_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_edge (
    .i_clk(clk), .i_rst_n(rst_n), .i_d(hub_clk), .o_rise(w_clk_rise)
  );

  hub75_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lat_edge (
    .i_clk(clk), .i_rst_n(rst_n), .i_d(hub_lat), .o_rise(w_lat_rise)
  );

  hub_state_e              r_state, w_state_n;
  logic [WIDTH-1:0][2:0]   r_sr_up, r_sr_lo, w_sr_up_n, w_sr_lo_n;
  logic [WIDTH-1:0][2:0]   r_buf_up, r_buf_lo;
  logic [CNT_W-1:0]        r_cnt, w_cnt_n;
  logic [ROW_BITS-1:0]     r_addr;
  logic                    r_len_err, r_overrun, r_oe_active;
  logic                    w_latch_idle;

  // Shift path; a shift in the latch cycle is included in what the latch captures.
  always_comb begin
    w_sr_up_n = r_sr_up;
    w_sr_lo_n = r_sr_lo;
    w_cnt_n   = r_cnt;
    if (w_clk_rise) begin
      w_sr_up_n = {r_sr_up[WIDTH-2:0], w_rgb1};
      w_sr_lo_n = {r_sr_lo[WIDTH-2:0], w_rgb2};
      if (r_cnt != CNT_W'(WIDTH + 1)) w_cnt_n = r_cnt + CNT_W'(1);
    end
  end

  assign w_latch_idle = w_lat_rise && (r_state == ST_IDLE);

  // Capture, line buffers and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr_up     <= '0;
      r_sr_lo     <= '0;
      r_buf_up    <= '0;
      r_buf_lo    <= '0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_len_err   <= 1'b0;
      r_overrun   <= 1'b0;
      r_oe_active <= 1'b0;
    end else begin
      r_sr_up     <= w_sr_up_n;
      r_sr_lo     <= w_sr_lo_n;
      r_cnt       <= w_lat_rise ? '0 : w_cnt_n;
      r_oe_active <= ~w_oe;
      if (w_latch_idle) begin
        r_buf_up <= w_sr_up_n;
        r_buf_lo <= w_sr_lo_n;
        r_addr   <= w_addr;
      end
      if (w_latch_idle && (w_cnt_n != CNT_W'(WIDTH))) r_len_err <= 1'b1;
      else if (clr_err)                                r_len_err <= 1'b0;
      if (w_lat_rise && (r_state != ST_IDLE)) r_overrun <= 1'b1;
      else if (clr_err)                       r_overrun <= 1'b0;
    end
  end

  // Readout FSM with registered pixel outputs.
  logic             r_valid, w_valid_n;
  logic             r_half, w_half_n;
  logic [COL_W-1:0] r_col, w_col_n;
  logic [2:0]       r_rgb, w_rgb_n;
  logic             w_done_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_half  <= HUB_HALF_UP;
      r_col   <= '0;
      r_rgb   <= '0;
    end else begin
      r_state <= w_state_n;
      r_valid <= w_valid_n;
      r_half  <= w_half_n;
      r_col   <= w_col_n;
      r_rgb   <= w_rgb_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_valid_n = r_valid;
    w_half_n  = r_half;
    w_col_n   = r_col;
    w_done_c  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_lat_rise) w_state_n = ST_EMIT_UP;
      end
      ST_EMIT_UP: begin
        if (!r_valid) begin
          // First cycle: line buffer is loaded, present column 0.
          w_valid_n = 1'b1;
          w_half_n  = HUB_HALF_UP;
          w_col_n   = '0;
        end else if (pix_ready) begin
          if (r_col == LAST_COL) begin
            w_half_n  = HUB_HALF_LO;
            w_col_n   = '0;
            w_state_n = ST_EMIT_LO;
          end else begin
            w_col_n = r_col + COL_W'(1);
          end
        end
      end
      ST_EMIT_LO: begin
        if (pix_ready) begin
          if (r_col == LAST_COL) begin
            w_valid_n = 1'b0;
            w_done_c  = 1'b1;
            w_state_n = ST_IDLE;
          end else begin
            w_col_n = r_col + COL_W'(1);
          end
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_valid_n = 1'b0;
      end
    endcase
    w_rgb_n = (w_half_n == HUB_HALF_LO) ? r_buf_lo[w_col_n] : r_buf_up[w_col_n];
  end

  assign pix_valid = r_valid;
  assign pix_row   = {r_half, r_addr};
  assign pix_col   = r_col;
  assign pix_rgb   = r_rgb;
  assign row_done  = w_done_c;
  assign oe_active = r_oe_active;
  assign len_err   = r_len_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_hub75_rx.sv
// Directed self-checking bench for hub75_rx (WIDTH=32, ROW_BITS=3, SYNC_STAGES=2).
module tb_hub75_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hub_clk, hub_lat, hub_oe, clr_err, pix_ready;
  logic [2:0] hub_addr, hub_rgb1, hub_rgb2;
  logic       pix_valid, row_done, oe_active, len_err, overrun;
  logic [3:0] pix_row;
  logic [4:0] pix_col;
  logic [2:0] pix_rgb;

  always #5 clk = ~clk;

  hub75_rx #(.WIDTH(32), .ROW_BITS(3), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe(hub_oe),
    .hub_addr(hub_addr), .hub_rgb1(hub_rgb1), .hub_rgb2(hub_rgb2), .clr_err(clr_err),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_row(pix_row), .pix_col(pix_col),
    .pix_rgb(pix_rgb), .row_done(row_done), .oe_active(oe_active), .len_err(len_err),
    .overrun(overrun)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [2:0] m_up [32];
  logic [2:0] m_lo [32];
  logic [2:0] exp_up [32];
  logic [2:0] exp_lo [32];
  logic [2:0] exp_addr;
  logic [3:0] got_row [64];
  logic [4:0] got_col [64];
  logic [2:0] got_rgb [64];
  int n_pix, n_done, done_idx, stall_left, stall_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [16:0] all_outs();
    return {pix_valid, pix_row, pix_col, pix_rgb, row_done, oe_active, len_err, overrun};
  endfunction

  // One panel shift: data set up 2 cycles, clock high 3 cycles, low afterwards.
  task automatic shift(input logic [2:0] a, input logic [2:0] b);
    @(negedge clk);
    hub_rgb1 = a;
    hub_rgb2 = b;
    repeat (2) @(negedge clk);
    hub_clk = 1'b1;
    for (int c = 31; c > 0; c--) begin
      m_up[c] = m_up[c-1];
      m_lo[c] = m_lo[c-1];
    end
    m_up[0] = a;
    m_lo[0] = b;
    repeat (3) @(negedge clk);
    hub_clk = 1'b0;
  endtask

  task automatic snap_expected(input logic [2:0] addr);
    for (int c = 0; c < 32; c++) begin
      exp_up[c] = m_up[c];
      exp_lo[c] = m_lo[c];
    end
    exp_addr = addr;
  endtask

  task automatic latch(input logic [2:0] addr, input bit capture);
    @(negedge clk);
    hub_addr = addr;
    hub_lat  = 1'b1;
    if (capture) snap_expected(addr);
    repeat (3) @(negedge clk);
    hub_lat = 1'b0;
  endtask

  // Accept pixels at negedges; optionally stall 10 cycles on upper column stall_at.
  task automatic collect(input int stall_at);
    n_pix = 0; n_done = 0; done_idx = -1; stall_bad = 0;
    stall_left = (stall_at >= 0) ? 10 : 0;
    for (int cyc = 0; cyc < 300 && n_pix < 64; cyc++) begin
      if (stall_left > 0 && pix_valid && int'(pix_col) == stall_at && !pix_row[3]) begin
        if (stall_left < 10 && {got_row[n_pix], got_col[n_pix], got_rgb[n_pix]} !==
            {pix_row, pix_col, pix_rgb}) stall_bad++;
        got_row[n_pix] = pix_row; got_col[n_pix] = pix_col; got_rgb[n_pix] = pix_rgb;
        pix_ready = 1'b0;
        stall_left--;
      end else begin
        pix_ready = 1'b1;
      end
      #1;
      if (row_done) begin n_done++; done_idx = n_pix; end
      if (pix_valid && pix_ready) begin
        got_row[n_pix] = pix_row; got_col[n_pix] = pix_col; got_rgb[n_pix] = pix_rgb;
        n_pix++;
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_pixels(input string tag);
    chk({tag, " count"}, 32'(n_pix), 32'd64);
    chk({tag, " row_done count"}, 32'(n_done), 32'd1);
    chk({tag, " row_done index"}, 32'(done_idx), 32'd63);
    for (int i = 0; i < 64; i++) begin
      logic       h;
      logic [4:0] c;
      logic [2:0] e;
      h = (i >= 32);
      c = 5'(i % 32);
      e = h ? exp_lo[c] : exp_up[c];
      chk($sformatf("%s px%0d", tag, i), 32'({got_row[i], got_col[i], got_rgb[i]}),
          32'({h, exp_addr, c, e}));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int found;
    logic [4:0] v;
    for (int c = 0; c < 32; c++) begin m_up[c] = '0; m_lo[c] = '0; end
    rst_n = 1'b0; hub_clk = 0; hub_lat = 0; hub_oe = 0; clr_err = 0; pix_ready = 0;
    hub_addr = 3'd7; hub_rgb1 = 3'b111; hub_rgb2 = 3'b111;

    // 1. Reset held: outputs stay 0 while pins toggle.
    for (int k = 0; k < 3; k++) begin
      repeat (4) @(negedge clk);
      hub_clk = ~hub_clk; hub_lat = ~hub_lat;
      chk($sformatf("reset held %0d", k), 32'(all_outs()), 32'd0);
    end
    hub_clk = 0; hub_lat = 0; hub_oe = 1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle after reset", 32'(all_outs()), 32'd0);
    hub_oe = 0;
    repeat (5) @(negedge clk);
    chk("oe_active high", 32'(oe_active), 32'd1);
    chk("oe no capture", 32'(pix_valid), 32'd0);
    hub_oe = 1;
    repeat (5) @(negedge clk);
    chk("oe_active low", 32'(oe_active), 32'd0);

    // 2. Constant row with latency measurement.
    for (int i = 0; i < 32; i++) shift(3'b100, 3'b001);
    pix_ready = 1'b1;
    @(negedge clk);
    hub_addr = 3'd5; hub_lat = 1'b1;
    snap_expected(3'd5);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 3) hub_lat = 1'b0;
      if (k == 4) chk("latency edge4 valid", 32'(pix_valid), 32'd0);
      if (k == 5) chk("latency edge5 valid", 32'(pix_valid), 32'd1);
    end
    collect(-1);
    check_pixels("const");
    chk("const upper rgb", 32'(got_rgb[5]), 32'b100);
    chk("const lower row", 32'({got_row[40], got_rgb[40]}), 32'({4'd13, 3'b001}));
    chk("const len_err", 32'(len_err), 32'd0);
    repeat (3) @(negedge clk);
    chk("const valid after", 32'(pix_valid), 32'd0);

    // 3. Column order: first shifted bit lands on column 31.
    shift(3'b100, 3'b000);
    for (int i = 1; i < 32; i++) shift(3'b000, 3'b000);
    latch(3'd0, 1'b1);
    collect(-1);
    check_pixels("order");
    chk("order col31", 32'({got_col[31], got_rgb[31]}), 32'({5'd31, 3'b100}));
    chk("order col0", 32'(got_rgb[0]), 32'd0);

    // 4. Backpressure on upper column 3.
    for (int i = 0; i < 32; i++) begin
      v = 5'(31 - i);
      shift(v[2:0], ~v[2:0]);
    end
    latch(3'd4, 1'b1);
    collect(3);
    check_pixels("bp");
    chk("bp stall done", 32'(stall_left), 32'd0);
    chk("bp stall stable", 32'(stall_bad), 32'd0);

    // 5. Short line sets len_err; clr_err clears it.
    for (int i = 0; i < 20; i++) shift(3'b010, 3'b110);
    latch(3'd2, 1'b1);
    collect(-1);
    check_pixels("short");
    chk("short col20 leftover", 32'(got_rgb[20]), 32'd0);
    chk("short len_err", 32'(len_err), 32'd1);
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    chk("short cleared", 32'(len_err), 32'd0);

    // 6a. Second latch during a stalled readout is dropped and flags overrun.
    pix_ready = 1'b0;
    for (int i = 0; i < 32; i++) shift(3'(i), 3'(i + 3));
    latch(3'd2, 1'b1);
    repeat (3) @(negedge clk);
    chk("ovr first valid", 32'({pix_valid, pix_col}), 32'({1'b1, 5'd0}));
    for (int i = 0; i < 32; i++) shift(3'b111, 3'b111);
    latch(3'd6, 1'b0);
    repeat (6) @(negedge clk);
    chk("ovr flag", 32'(overrun), 32'd1);
    chk("ovr still col0", 32'({pix_valid, pix_row, pix_col}), 32'({1'b1, 4'd2, 5'd0}));
    collect(-1);
    check_pixels("ovr");
    cnt = 0;
    for (int k = 0; k < 60; k++) begin @(negedge clk); if (pix_valid) cnt++; end
    chk("ovr dropped", 32'(cnt), 32'd0);
    chk("ovr no len_err", 32'(len_err), 32'd0);
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    chk("ovr cleared", 32'(overrun), 32'd0);

    // 6b. Shift and latch edges in the same cycle.
    for (int i = 0; i < 31; i++) shift(3'b000, 3'b000);
    @(negedge clk);
    hub_rgb1 = 3'b111; hub_rgb2 = 3'b011;
    repeat (2) @(negedge clk);
    for (int c = 31; c > 0; c--) begin m_up[c] = m_up[c-1]; m_lo[c] = m_lo[c-1]; end
    m_up[0] = 3'b111; m_lo[0] = 3'b011;
    hub_addr = 3'd3;
    snap_expected(3'd3);
    hub_clk = 1'b1; hub_lat = 1'b1;
    repeat (3) @(negedge clk);
    hub_clk = 1'b0; hub_lat = 1'b0;
    collect(-1);
    check_pixels("simul");
    chk("simul up col0", 32'({got_col[0], got_rgb[0]}), 32'({5'd0, 3'b111}));
    chk("simul lo col0", 32'({got_row[32], got_rgb[32]}), 32'({4'd11, 3'b011}));
    chk("simul len_err", 32'(len_err), 32'd0);

    // 1b. Reset asserted mid-stream at column 10.
    for (int i = 0; i < 32; i++) shift(3'b101, 3'b010);
    latch(3'd1, 1'b0);
    pix_ready = 1'b1;
    found = 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      if (pix_valid && pix_col == 5'd10) found = 1;
      else @(negedge clk);
    end
    chk("midreset reached col10", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset outputs", 32'(all_outs()), 32'd0);
    @(negedge clk);
    chk("midreset next valid", 32'(pix_valid), 32'd0);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      #1;
      if (pix_valid || row_done) cnt++;
    end
    chk("midreset quiet", 32'(cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
